// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and timer limits shared by the alarm sequencer files
package alarm_pkg;
    localparam int COUNTS_MAX_DEFAULT = 1024;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EXIT_DELAY = 3'd1,
        ARMED      = 3'd2,
        ALARM      = 3'd3,
        COOLDOWN   = 3'd4
    } state_t;
endpackage

// File: rtl/motion_confirm.sv
// motion_confirm: saturating motion-hit counter, cleared by a motion-free frame or when disabled
module motion_confirm #(
    parameter int CONFIRM_HITS = 3,
    localparam int HW = $clog2(CONFIRM_HITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          motion,
    input  logic          frame_end,
    output logic [HW-1:0] hits
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hits <= '0;
        else if (!en) hits <= '0;
        else if (motion) hits <= hits == HW'(CONFIRM_HITS) ? hits : hits + 1'b1;
        else if (frame_end) hits <= '0;
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arm / alarm / cooldown controller driving one shared, non-abortable 10 ms timer
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int COUNTS_MAX     = COUNTS_MAX_DEFAULT,
    parameter int ARM_TICKS      = 500,
    parameter int ALARM_TICKS    = 1000,
    parameter int COOLDOWN_TICKS = 200,
    parameter int CONFIRM_HITS   = 3,
    localparam int CL = $clog2(COUNTS_MAX)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        disarm,
    input  logic        motion,
    input  logic        frame_end,
    output logic        timer_start,
    output logic [CL:0] timer_counts,
    input  logic        timer_done,
    output logic        snap_req,
    input  logic        snap_ack,
    output logic        alarm,
    output logic        armed,
    output logic [2:0]  state_o
);
    localparam int HW = $clog2(CONFIRM_HITS + 1);
    localparam logic [CL:0] ARM_C = (CL+1)'(ARM_TICKS);
    localparam logic [CL:0] ALARM_C = (CL+1)'(ALARM_TICKS);
    localparam logic [CL:0] COOL_C = (CL+1)'(COOLDOWN_TICKS);

    state_t state, state_d;
    logic busy, stale, pend, go, tdone, start_d, snap_d, confirmed;
    logic [CL:0] counts_d;
    logic [HW-1:0] hits;

    motion_confirm #(.CONFIRM_HITS(CONFIRM_HITS)) u_confirm (
        .clk(clk),
        .rst_n(rst_n),
        .en(state == ARMED),
        .motion(motion),
        .frame_end(frame_end),
        .hits(hits)
    );

    assign confirmed = hits == HW'(CONFIRM_HITS);
    // a done belonging to a run abandoned by disarm (stale) must not advance the FSM
    assign tdone = timer_done & busy & ~stale;
    assign go = (arm | pend) & ~busy;
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            timer_start  <= 1'b0;
            timer_counts <= '0;
            snap_req     <= 1'b0;
            alarm        <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
            stale        <= 1'b0;
            pend         <= 1'b0;
        end else begin
            state        <= state_d;
            timer_start  <= start_d;
            timer_counts <= counts_d;
            snap_req     <= snap_d;
            alarm        <= state_d == ALARM;
            armed        <= state_d == ARMED;
            busy         <= start_d | (busy & ~timer_done);
            stale        <= ~timer_done & (stale | (disarm & busy));
            pend         <= ~disarm & (state == IDLE) & ((arm & busy) | (pend & ~go));
        end

    always_comb begin
        state_d = state;
        if (disarm) state_d = IDLE;
        else
            case (state)
                IDLE:                 state_d = go ? EXIT_DELAY : IDLE;
                EXIT_DELAY, COOLDOWN: state_d = tdone ? ARMED : state;
                ARMED:                state_d = confirmed ? ALARM : ARMED;
                ALARM:                state_d = tdone ? COOLDOWN : ALARM;
                default:              state_d = IDLE;
            endcase
    end

    always_comb begin
        start_d = state_d != state && (state_d == EXIT_DELAY || state_d == ALARM || state_d == COOLDOWN);
        counts_d = !start_d ? timer_counts : state_d == EXIT_DELAY ? ARM_C : state_d == ALARM ? ALARM_C : COOL_C;
        snap_d = !disarm && ((start_d && state_d == ALARM) || (snap_req && !snap_ack));
    end
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed scenarios then randomized traffic, checked against a reference model
module tb_alarm_sequencer;
    import alarm_pkg::*;
    localparam int CH = 3, AT = 500, LT = 1000, CT = 200;

    logic clk = 1'b0, rst_n = 1'b0;
    logic arm = 1'b0, disarm = 1'b0, motion = 1'b0, frame_end = 1'b0, timer_done = 1'b0, snap_ack = 1'b0;
    logic timer_start, snap_req, alarm, armed;
    logic [10:0] timer_counts;
    logic [2:0] state_o;
    int n_pass = 0, n_chk = 0, tleft = 0;

    state_t m_state;
    int m_hits, m_counts;
    bit m_start, m_snap, m_busy, m_stale, m_pend;

    alarm_sequencer dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .motion(motion),
        .frame_end(frame_end), .timer_start(timer_start), .timer_counts(timer_counts),
        .timer_done(timer_done), .snap_req(snap_req), .snap_ack(snap_ack),
        .alarm(alarm), .armed(armed), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state = IDLE; m_hits = 0; m_counts = 0;
        m_start = 0; m_snap = 0; m_busy = 0; m_stale = 0; m_pend = 0;
    endtask

    // one clock of the specified behaviour, from the inputs seen at the edge
    task automatic model_clock(input bit a, d, m, f, t, k);
        state_t nxt;
        bit vdone, fire;
        vdone = t && m_busy && !m_stale;
        nxt = m_state;
        if (d) nxt = IDLE;
        else if (m_state == IDLE) begin
            if ((a || m_pend) && !m_busy) nxt = EXIT_DELAY;
        end else if (m_state == ARMED) begin
            if (m_hits == CH) nxt = ALARM;
        end else if (vdone) nxt = m_state == ALARM ? COOLDOWN : ARMED;
        fire = nxt != m_state && nxt inside {EXIT_DELAY, ALARM, COOLDOWN};
        m_pend = !d && ((m_state == IDLE && a && m_busy) || (m_pend && nxt == IDLE));
        m_stale = t ? 1'b0 : (m_stale || (d && m_busy));
        m_busy = fire || (m_busy && !t);
        m_hits = m_state != ARMED ? 0 : m ? (m_hits < CH ? m_hits + 1 : CH) : f ? 0 : m_hits;
        m_snap = !d && ((fire && nxt == ALARM) || (m_snap && !k));
        if (fire) m_counts = nxt == EXIT_DELAY ? AT : nxt == ALARM ? LT : CT;
        m_start = fire;
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("state_o", 32'(state_o), int'(m_state));
        chk("timer_start", 32'(timer_start), 32'(m_start));
        chk("timer_counts", 32'(timer_counts), m_counts);
        chk("snap_req", 32'(snap_req), 32'(m_snap));
        chk("alarm", 32'(alarm), 32'(m_state == ALARM));
        chk("armed", 32'(armed), 32'(m_state == ARMED));
        chk("hits", 32'(dut.u_confirm.hits), m_hits);
    endtask

    task automatic step(input bit a, d, m, f, t, k);
        arm = a; disarm = d; motion = m; frame_end = f; timer_done = t; snap_ack = k;
        @(posedge clk);
        model_clock(a, d, m, f, t, k);
        #1;
        arm = 0; disarm = 0; motion = 0; frame_end = 0; timer_done = 0; snap_ack = 0;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // arming with exit delay; motion ignored meanwhile
        step(1, 0, 0, 0, 0, 0);
        chk("arm_start", 32'(timer_start), 1);
        chk("arm_counts", 32'(timer_counts), AT);
        repeat (3) step(0, 0, 1, 1, 0, 0);
        chk("exit_no_arm", 32'(armed), 0);
        step(0, 0, 0, 0, 1, 0);
        chk("armed_after_done", 32'(armed), 1);
        step(1, 0, 0, 0, 1, 0);
        chk("spurious_done", 32'(state_o), int'(ARMED));
        // frame window
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("window_hits", 32'(dut.u_confirm.hits), 1);
        chk("window_alarm", 32'(alarm), 0);
        // trigger and snapshot handshake
        step(0, 0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("trig_alarm", 32'(alarm), 1);
        chk("trig_snap", 32'(snap_req), 1);
        chk("trig_counts", 32'(timer_counts), LT);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("snap_drop", 32'(snap_req), 0);
        // cooldown
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("cool_counts", 32'(timer_counts), CT);
        chk("cool_alarm", 32'(alarm), 0);
        repeat (3) step(0, 0, 1, 1, 0, 0);
        chk("cool_state", 32'(state_o), int'(COOLDOWN));
        step(0, 0, 0, 0, 1, 0);
        chk("rearm_state", 32'(state_o), int'(ARMED));
        chk("rearm_hits", 32'(dut.u_confirm.hits), 0);
        // stale done and pending arm
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("disarm_wins", 32'(state_o), int'(IDLE));
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("pend_no_start", 32'(timer_start), 0);
        step(0, 0, 0, 0, 1, 0);
        chk("stale_swallowed", 32'(state_o), int'(IDLE));
        step(0, 0, 0, 0, 0, 0);
        chk("pend_start", 32'(timer_start), 1);
        chk("pend_counts", 32'(timer_counts), AT);
        chk("pend_not_armed", 32'(armed), 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("pend_armed", 32'(armed), 1);
        // asynchronous reset in ALARM
        repeat (3) step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("pre_reset_alarm", 32'(alarm), 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_alarm", 32'(alarm), 0);
        chk("async_state", 32'(state_o), int'(IDLE));
        check_all();
        @(negedge clk) rst_n = 1'b1;
        // randomized traffic with a bench-side timer that keeps running across disarms
        tleft = 0;
        repeat (3000) begin
            logic t_i;
            t_i = tleft == 1 || (tleft == 0 && $urandom_range(0, 39) == 0);
            if (tleft > 0) tleft--;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, t_i, snap_req && $urandom_range(0, 2) == 0);
            if (timer_start) tleft = $urandom_range(1, 12);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter COUNTS_MAX, default 1024, the maximum tick count accepted by the downstream 10 ms timer; CL = $clog2(COUNTS_MAX).
REQ-002 SHALL have parameter ARM_TICKS, default 500, the exit delay before arming, in 10 ms ticks.
REQ-003 SHALL have parameter ALARM_TICKS, default 1000, the alarm hold time, in ticks.
REQ-004 SHALL have parameter COOLDOWN_TICKS, default 200, the re-arm holdoff, in ticks.
REQ-005 SHALL have parameter CONFIRM_HITS, default 3, the motion pulses needed to trigger.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port arm, input, 1 bit: single-cycle arm request.
REQ-009 SHALL have port disarm, input, 1 bit: single-cycle disarm request.
REQ-010 SHALL have port motion, input, 1 bit: single-cycle pulse, one per frame with detected change.
REQ-011 SHALL have port frame_end, input, 1 bit: single-cycle pulse, one per camera frame.
REQ-012 SHALL have port timer_start, output, 1 bit: single-cycle start to the 10 ms timer.
REQ-013 SHALL have port timer_counts, output, CL+1 bits: tick count presented to the timer.
REQ-014 SHALL have port timer_done, input, 1 bit: single-cycle expiry pulse from the timer.
REQ-015 SHALL have port snap_req, output, 1 bit: snapshot request to the frame store, held until acknowledged.
REQ-016 SHALL have port snap_ack, input, 1 bit: snapshot accepted.
REQ-017 SHALL have port alarm, output, 1 bit: siren/LED drive.
REQ-018 SHALL have port armed, output, 1 bit: high in the ARMED state.
REQ-019 SHALL have port state_o, output, 3 bits: current state encoding, for debug.

Function
REQ-020 SHALL implement states IDLE, EXIT_DELAY, ARMED, ALARM and COOLDOWN; all outputs SHALL be registered.
REQ-021 SHALL transition IDLE -> EXIT_DELAY on arm: pulse timer_start for one cycle and drive timer_counts = ARM_TICKS.
REQ-022 SHALL transition EXIT_DELAY -> ARMED on timer_done; motion SHALL be ignored during EXIT_DELAY.
REQ-023 SHALL, in ARMED, count motion pulses in a hit counter; frame_end without motion in the same cycle SHALL clear the counter.
REQ-024 SHALL, when the hit counter reaches CONFIRM_HITS, go to ALARM, assert alarm, raise snap_req, and start the timer with ALARM_TICKS.
REQ-025 SHALL keep snap_req high until the cycle snap_ack is sampled high, then drop it the next cycle; at most one snapshot SHALL be issued per ALARM entry.
REQ-026 SHALL transition ALARM -> COOLDOWN on timer_done: deassert alarm and start the timer with COOLDOWN_TICKS.
REQ-027 SHALL transition COOLDOWN -> ARMED on timer_done, with the hit counter cleared.
REQ-028 SHALL, on disarm in any state, go to IDLE the next cycle with alarm = 0 and snap_req = 0.
REQ-029 SHALL treat disarm as winning over arm and motion when they occur in the same cycle.
REQ-030 SHALL track timer_busy (set at timer_start, cleared at timer_done), because the timer cannot be aborted.
REQ-031 SHALL, after a disarm with timer_busy set, swallow the next timer_done; an arm arriving while timer_busy SHALL be held pending and serviced one cycle after that done.
REQ-032 SHALL hold timer_counts stable from timer_start until timer_done.
REQ-033 SHALL ignore arm received in any state other than IDLE.
REQ-034 SHALL saturate the hit counter at CONFIRM_HITS; it SHALL never wrap.
REQ-035 SHALL treat a timer_done arriving while the timer is not busy as spurious and ignore it.

Reset
REQ-036 SHALL, while rst_n is low, asynchronously set state = IDLE, timer_start = 0, timer_counts = 0, snap_req = 0, alarm = 0, armed = 0, hit counter = 0, timer_busy = 0 and the pending-arm flag = 0.
REQ-037 SHALL, after rst_n deasserts, treat the first clk edge as the first operational cycle.

Structure
REQ-038 SHALL place the state_t enum and the COUNTS_MAX default in the shared package alarm_pkg.
REQ-039 SHALL implement the hit counter and frame-window clearing (REQ-023, REQ-034) as sub-module motion_confirm.

Verification
REQ-040 SHALL cover basic arming: arm; timer_done -> timer_start with timer_counts = 500, then armed = 1 the cycle after done.
REQ-041 SHALL cover triggering: 3 motion pulses in consecutive frames while armed -> alarm = 1, snap_req = 1, timer_counts = 1000; snap_ack after 5 cycles -> snap_req = 0 the next cycle.
REQ-042 SHALL cover the frame window: motion, motion, a motion-free frame_end, then motion -> no alarm, hit count = 1.
REQ-043 SHALL cover stale done: disarm during EXIT_DELAY, arm 10 cycles later, then stale timer_done -> done swallowed, new timer_start with 500, armed = 0 until the second done.
REQ-044 SHALL cover the full cycle: ALARM done -> COOLDOWN with timer_counts = 200; motion during COOLDOWN ignored; done -> ARMED with hit count = 0.
REQ-045 SHALL cover reset mid-operation: assert rst_n low during ALARM asynchronously -> alarm = 0, state_o = IDLE, with no clk edge required.
